// File: rtl/receptor_serial_fifo.sv
// receptor_serial_fifo: UART receive path (8N1/8E1/8O1) with a two-flop line
// synchroniser, 3-sample majority voting per bit, and a show-ahead FIFO that
// hands good bytes to the consumer through a ler/dado_pronto pop handshake.
//
// state        | meaning
// ESPERA_LINHA | wait for an idle-high line (after reset or after a break)
// OCIOSO       | idle, watching for a start edge
// START        | timing the start bit, rejecting false starts
// DADOS        | receiving 8 data bits, LSB first
// PARIDADE_ST  | receiving the parity bit
// STOP         | checking the stop bit at mid-bit, then store or flag
module receptor_serial_fifo #(
  parameter int CLOCKS_POR_BIT    = 5208,
  parameter int PARIDADE          = 0,
  parameter int PROFUNDIDADE_FIFO = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       ler,
  output logic [7:0] dado,
  output logic       dado_pronto,
  output logic       ocupado,
  output logic       erro_quadro,
  output logic       erro_paridade,
  output logic       estouro
);
  localparam int CW = $clog2(CLOCKS_POR_BIT);
  localparam int AW = $clog2(PROFUNDIDADE_FIFO);
  localparam int OW = AW + 1;
  localparam logic [CW-1:0] CNT_FIM = CW'(CLOCKS_POR_BIT - 1);
  localparam logic [CW-1:0] CNT_A   = CW'(CLOCKS_POR_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_B   = CW'(CLOCKS_POR_BIT / 2);
  localparam logic [CW-1:0] CNT_C   = CW'(CLOCKS_POR_BIT / 2 + 1);
  localparam logic [OW-1:0] CHEIO   = OW'(PROFUNDIDADE_FIFO);

  typedef enum logic [2:0] {
    ESPERA_LINHA, OCIOSO, START, DADOS, PARIDADE_ST, STOP
  } estado_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          sinc_a, sinc_b, linha;
  logic [1:0]    sinc_ok;
  estado_t       estado;
  logic [CW-1:0] cnt;
  logic [2:0]    amostras;
  logic [2:0]    idx_bit;
  logic [7:0]    captura;
  logic          par_acc, erro_par_pend;
  logic          fim_bit, bit_maj, maj_stop, decisao, escrita;

  logic [7:0]    mem [PROFUNDIDADE_FIFO];
  logic [AW-1:0] ptr_esc, ptr_lei, ptr_lei_prox;
  logic [OW-1:0] ocupacao, ocup_apos_pop, ocup_prox;
  logic          pop, aceita;

  assign linha   = sinc_b;
  assign fim_bit = (cnt == CNT_FIM);
  assign bit_maj = maj3(amostras[2], amostras[1], amostras[0]);
  // The stop decision happens on the third sample's own cycle, so the live
  // line value stands in for the sample not yet shifted in.
  assign maj_stop = maj3(amostras[1], amostras[0], linha);
  assign decisao  = (estado == STOP) && (cnt == CNT_C);
  assign escrita  = decisao && maj_stop && !erro_par_pend;

  // Line synchroniser; sinc_ok keeps ESPERA_LINHA from trusting the forced-high
  // reset value before the real line level has propagated through.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc_a  <= 1'b1;
      sinc_b  <= 1'b1;
      sinc_ok <= 2'b00;
    end else begin
      sinc_a  <= entrada_serial;
      sinc_b  <= sinc_a;
      sinc_ok <= {sinc_ok[0], 1'b1};
    end
  end

  // Receiver FSM: bit timing, majority sampling, framing and parity checks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= ESPERA_LINHA;
      cnt           <= '0;
      amostras      <= '0;
      idx_bit       <= '0;
      captura       <= '0;
      par_acc       <= 1'b0;
      erro_par_pend <= 1'b0;
      ocupado       <= 1'b0;
      erro_quadro   <= 1'b0;
      erro_paridade <= 1'b0;
    end else begin
      erro_quadro   <= 1'b0;
      erro_paridade <= 1'b0;
      ocupado       <= (estado != OCIOSO);
      if (cnt == CNT_A || cnt == CNT_B || cnt == CNT_C)
        amostras <= {amostras[1:0], linha};
      cnt <= fim_bit ? '0 : cnt + 1'b1;
      unique case (estado)
        ESPERA_LINHA: begin
          cnt <= '0;
          if (sinc_ok[1] && linha) begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end
        OCIOSO: begin
          // The transition cycle is count 0; the default increment gives 1 next.
          if (linha) cnt <= '0;
          else begin
            estado  <= START;
            ocupado <= 1'b1;
          end
        end
        START: if (fim_bit) begin
          if (bit_maj) begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end else begin
            estado        <= DADOS;
            idx_bit       <= '0;
            par_acc       <= 1'b0;
            erro_par_pend <= 1'b0;
          end
        end
        DADOS: if (fim_bit) begin
          captura <= {bit_maj, captura[7:1]};
          par_acc <= par_acc ^ bit_maj;
          idx_bit <= idx_bit + 1'b1;
          if (idx_bit == 3'd7) estado <= (PARIDADE != 0) ? PARIDADE_ST : STOP;
        end
        PARIDADE_ST: if (fim_bit) begin
          erro_par_pend <= ((par_acc ^ bit_maj) != (PARIDADE == 2));
          estado        <= STOP;
        end
        STOP: if (decisao) begin
          cnt <= '0;
          if (!maj_stop) begin
            erro_quadro <= 1'b1;
            estado      <= ESPERA_LINHA;
          end else begin
            if (erro_par_pend) erro_paridade <= 1'b1;
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end
        default: estado <= ESPERA_LINHA;
      endcase
    end
  end

  assign pop           = ler && dado_pronto;
  assign aceita        = escrita && ((ocupacao != CHEIO) || pop);
  assign ptr_lei_prox  = pop ? ptr_lei + 1'b1 : ptr_lei;
  assign ocup_apos_pop = pop ? ocupacao - 1'b1 : ocupacao;
  assign ocup_prox     = aceita ? ocup_apos_pop + 1'b1 : ocup_apos_pop;

  // FIFO storage
  always_ff @(posedge clock) begin
    if (aceita) mem[ptr_esc] <= captura;
  end

  // FIFO pointers, overflow pulse and registered show-ahead head
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_esc     <= '0;
      ptr_lei     <= '0;
      ocupacao    <= '0;
      dado        <= '0;
      dado_pronto <= 1'b0;
      estouro     <= 1'b0;
    end else begin
      estouro     <= escrita && !aceita;
      if (aceita) ptr_esc <= ptr_esc + 1'b1;
      ptr_lei     <= ptr_lei_prox;
      ocupacao    <= ocup_prox;
      dado_pronto <= (ocup_prox != '0);
      // When the FIFO is empty apart from the byte landing now, the head is
      // that byte, which is not yet readable from mem.
      if (ocup_prox == '0)          dado <= '0;
      else if (ocup_apos_pop == '0) dado <= captura;
      else                          dado <= mem[ptr_lei_prox];
    end
  end

endmodule

// File: tb/tb_receptor_serial_fifo.sv
// Bench for receptor_serial_fifo: three instances (no / even / odd parity),
// bit-level frame driver, reference queue model and a decoupled monitor.
module tb_receptor_serial_fifo;
  localparam int CPB   = 16;
  localparam int M     = CPB / 2;
  localparam int DEPTH = 4;
  localparam logic [2:0] F_QUADRO = 3'b001;
  localparam logic [2:0] F_PAR    = 3'b010;
  localparam logic [2:0] F_EST    = 3'b100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       linha [3];
  logic       ler [3];
  logic [7:0] dado [3];
  logic       dado_pronto [3];
  logic       ocupado [3];
  logic       erro_quadro [3];
  logic       erro_paridade [3];
  logic       estouro [3];

  logic [7:0] mdl_q [3][$];
  logic [2:0] flg_q [3][$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    receptor_serial_fifo #(
      .CLOCKS_POR_BIT(CPB), .PARIDADE(g), .PROFUNDIDADE_FIFO(DEPTH)
    ) dut (
      .clock(clock), .reset(reset), .entrada_serial(linha[g]), .ler(ler[g]),
      .dado(dado[g]), .dado_pronto(dado_pronto[g]), .ocupado(ocupado[g]),
      .erro_quadro(erro_quadro[g]), .erro_paridade(erro_paridade[g]),
      .estouro(estouro[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every pop and every flag pulse is matched against the model.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (dado_pronto[k] && ler[k]) begin
        if (mdl_q[k].size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL pop_u%0d: got byte 0x%0h, expected no data", k, dado[k]);
        end else
          chk($sformatf("pop_u%0d", k), int'(dado[k]), int'(mdl_q[k].pop_front()));
      end
      if ({estouro[k], erro_paridade[k], erro_quadro[k]} != 3'b000) begin
        if (flg_q[k].size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL flag_u%0d: got %b, expected none", k,
                   {estouro[k], erro_paridade[k], erro_quadro[k]});
        end else
          chk($sformatf("flag_u%0d", k), int'({estouro[k], erro_paridade[k], erro_quadro[k]}),
              int'(flg_q[k].pop_front()));
      end
    end
  end

  // Drive one frame on instance k and record its expected outcome first.
  task automatic send(input int k, input logic [7:0] b, input logic pbit, input logic stop,
                      input int glitch_t, input bit pop_plan, input int hold_low);
    int nb, t_ler;
    logic [10:0] bits;
    nb = (k != 0) ? 11 : 10;
    if (!stop)                                              flg_q[k].push_back(F_QUADRO);
    else if (k == 1 && (($countones(b) + pbit) % 2) != 0)   flg_q[k].push_back(F_PAR);
    else if (k == 2 && (($countones(b) + pbit) % 2) != 1)   flg_q[k].push_back(F_PAR);
    else if (mdl_q[k].size() >= DEPTH && !pop_plan)         flg_q[k].push_back(F_EST);
    else                                                    mdl_q[k].push_back(b);
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (nb == 11) bits[9] = pbit;
    bits[nb-1] = stop;
    t_ler = 3 + (nb - 1) * CPB + M;
    @(posedge clock); #1;
    for (int t = 0; t < nb * CPB; t++) begin
      linha[k] = bits[t / CPB] ^ (t == glitch_t);
      ler[k]   = pop_plan && (t == t_ler);
      @(posedge clock); #1;
    end
    ler[k] = 1'b0;
    if (hold_low > 0) begin
      linha[k] = 1'b0;
      repeat (hold_low) @(posedge clock);
      #1;
    end
    linha[k] = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic read_one(input int k);
    int w;
    w = 0;
    while (!dado_pronto[k] && w < 50) begin
      @(posedge clock); #1;
      w++;
    end
    if (!dado_pronto[k]) begin
      n_vec++; n_err++;
      $display("FAIL read_timeout_u%0d: dado_pronto stayed 0, expected 1", k);
    end else begin
      ler[k] = 1'b1;
      @(posedge clock); #1;
      ler[k] = 1'b0;
      chk($sformatf("pronto_after_pop_u%0d", k), int'(dado_pronto[k]), int'(mdl_q[k].size() != 0));
    end
  endtask

  task automatic chk_state(input int k);
    chk($sformatf("pronto_u%0d", k), int'(dado_pronto[k]), int'(mdl_q[k].size() != 0));
    chk($sformatf("head_u%0d", k), int'(dado[k]),
        (mdl_q[k].size() != 0) ? int'(mdl_q[k][0]) : 0);
  endtask

  task automatic chk_zero(input int k);
    chk($sformatf("rst_dado_u%0d", k), int'(dado[k]), 0);
    chk($sformatf("rst_pronto_u%0d", k), int'(dado_pronto[k]), 0);
    chk($sformatf("rst_ocupado_u%0d", k), int'(ocupado[k]), 0);
    chk($sformatf("rst_quadro_u%0d", k), int'(erro_quadro[k]), 0);
    chk($sformatf("rst_paridade_u%0d", k), int'(erro_paridade[k]), 0);
    chk($sformatf("rst_estouro_u%0d", k), int'(estouro[k]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic       pb, sp;
    int         k;
    logic [9:0] fr;
    for (int i = 0; i < 3; i++) begin
      linha[i] = 1'b1;
      ler[i]   = 1'b0;
    end
    #1 reset = 1'b0;
    #11;
    for (int i = 0; i < 3; i++) chk_zero(i);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;

    // basic frame
    send(0, 8'h41, 1'b0, 1'b1, -1, 1'b0, 0);
    chk_state(0);
    read_one(0);

    // 4-clock low glitch: false start
    linha[0] = 1'b0;
    repeat (4) @(posedge clock);
    #1 linha[0] = 1'b1;
    repeat (4) @(posedge clock);
    #1 chk("glitch_ocupado_busy", int'(ocupado[0]), 1);
    repeat (12) @(posedge clock);
    #1 chk("glitch_ocupado_idle", int'(ocupado[0]), 0);
    chk_state(0);

    // single-sample inversion at the middle sample of data bit 3
    send(0, 8'h31, 1'b0, 1'b1, 4 * CPB + M, 1'b0, 0);
    chk_state(0);
    read_one(0);

    // framing error followed by a long break, then a normal byte
    send(0, 8'h55, 1'b0, 1'b0, -1, 1'b0, 40);
    chk_state(0);
    send(0, 8'h31, 1'b0, 1'b1, -1, 1'b0, 0);
    chk_state(0);
    read_one(0);

    // parity: even on instance 1, odd on instance 2
    send(1, 8'h07, 1'b0, 1'b1, -1, 1'b0, 0);
    chk_state(1);
    send(1, 8'h07, 1'b1, 1'b1, -1, 1'b0, 0);
    chk_state(1);
    read_one(1);
    send(2, 8'h07, 1'b1, 1'b1, -1, 1'b0, 0);
    chk_state(2);
    send(2, 8'h07, 1'b0, 1'b1, -1, 1'b0, 0);
    chk_state(2);
    read_one(2);

    // overflow, drain, refill, then write while popping on a full FIFO
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b1, -1, 1'b0, 0);
    chk_state(0);
    for (int i = 0; i < 4; i++) read_one(0);
    chk_state(0);
    for (int i = 1; i <= 4; i++) send(0, 8'(8'h10 + i), 1'b0, 1'b1, -1, 1'b0, 0);
    send(0, 8'h15, 1'b0, 1'b1, -1, 1'b1, 0);
    chk_state(0);
    for (int i = 0; i < 4; i++) read_one(0);
    chk_state(0);

    // randomized frames across the three parity modes
    for (int n = 0; n < 24; n++) begin
      k  = $urandom_range(0, 2);
      b  = 8'($urandom);
      pb = (k == 2) ? ~(^b) : ^b;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      sp = ($urandom_range(0, 7) != 0);
      send(k, b, pb, sp, -1, 1'b0, 0);
      chk_state(k);
      if ($urandom_range(0, 1) == 1 && mdl_q[k].size() != 0) read_one(k);
    end
    for (int i = 0; i < 3; i++)
      while (mdl_q[i].size() != 0) read_one(i);

    // reset in the middle of a frame, released with the line low
    send(0, 8'h3C, 1'b0, 1'b1, -1, 1'b0, 0);
    chk_state(0);
    fr = {1'b1, 8'hA5, 1'b0};
    @(posedge clock); #1;
    for (int t = 0; t < 5 * CPB + M; t++) begin
      linha[0] = fr[t / CPB];
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) chk_zero(i);
    for (int i = 0; i < 3; i++) mdl_q[i].delete();
    linha[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (200) @(posedge clock);
    #1;
    chk("low_after_rst_pronto", int'(dado_pronto[0]), 0);
    chk("low_after_rst_ocupado", int'(ocupado[0]), 1);
    linha[0] = 1'b1;
    repeat (5) @(posedge clock);
    #1 chk("line_high_ocupado", int'(ocupado[0]), 0);
    send(0, 8'hA5, 1'b0, 1'b1, -1, 1'b0, 0);
    chk_state(0);
    read_one(0);

    repeat (5) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("end_flags_left_u%0d", i), flg_q[i].size(), 0);
      chk($sformatf("end_pronto_u%0d", i), int'(dado_pronto[i]), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
